vending_machine: RTL and testbench
==================================

VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 SHALL expose: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL expose: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL expose: coin  input  2  coin sampled each rising edge: 00 none, 01 Rs5, 10 Rs10, 11 invalid.
REQ-004 SHALL expose: dispense  output  1  one-cycle pulse, product released.
REQ-005 SHALL expose: change  output  2  change returned with dispense: 00 none, 01 Rs5, 10 Rs10, 11 reserved and never driven.
REQ-006 SHALL have one parameter: PRICE, default 15, product price in rupees; legal values are 5, 10 and 15, and only 15 is required to be verified.

Function
REQ-007 SHALL use a credit FSM with states IDLE (Rs0), CREDIT5 (Rs5) and CREDIT10 (Rs10).
REQ-008 SHALL sample coin once per rising edge, so each cycle with a non-zero legal code counts as exactly one coin.
REQ-009 SHALL treat coin=11 as no coin: state unchanged, no dispense, no change.
REQ-010 SHALL compute total = current credit + coin value (0, 5 or 10) on each edge; total range 0..20, 5-bit arithmetic, no overflow.
REQ-011 SHALL, when total < PRICE, move to the state that encodes total, with dispense=0 and change=00 on the next cycle.
REQ-012 SHALL, when total >= PRICE, return to IDLE, assert dispense=1 for exactly the next cycle, and drive change = encoding of (total - PRICE).
REQ-013 SHALL produce these transitions for PRICE=15:
- IDLE+5 -> CREDIT5
- IDLE+10 -> CREDIT10
- CREDIT5+5 -> CREDIT10
- CREDIT5+10 -> IDLE, dispense, change 00
- CREDIT10+5 -> IDLE, dispense, change 00
- CREDIT10+10 -> IDLE, dispense, change 01
REQ-014 SHALL register outputs: dispense/change reflect the coin sampled at edge N during the cycle after edge N (latency 1), and SHALL be glitch-free.
REQ-015 SHALL hold change at 00 whenever dispense=0.
REQ-016 SHALL process a coin presented in the cycle in which dispense is high normally from IDLE credit, allowing back-to-back sales. Example: Rs10 immediately after a vend gives CREDIT10 with no dispense.
REQ-017 SHALL keep credit indefinitely while coin=00; there is no timeout or refund.
REQ-018 SHALL dispense at most once per edge, and never with credit remaining afterwards.

Reset
REQ-019 SHALL, with reset=1 at a rising edge, go to IDLE with dispense=0 and change=00 regardless of coin.
REQ-020 SHALL forfeit any accumulated credit on a reset during a partial purchase, with no change returned.
REQ-021 SHALL give reset priority over a coin sampled on the same edge.
REQ-022 SHALL guarantee a defined IDLE state and zero outputs after the first reset edge; power-up values before that are not required.

Structure
REQ-023 SHALL take the following from a shared package vending_pkg:
- state enum (IDLE, CREDIT5, CREDIT10)
- coin codes (COIN_NONE, COIN_5, COIN_10, COIN_INV)
- change codes (CHG_NONE, CHG_5, CHG_10)
- value constants VAL_5=5 and VAL_10=10
REQ-024 SHALL be implemented as one state register plus combinational next-state/output logic feeding the output registers.
REQ-025 MAY use one sub-module, vending_coin_decode (2-bit code to rupee value plus valid flag); no other hierarchy.

Verification
REQ-026 SHALL verify: reset 1 cycle, then Rs5, Rs10, none -> dispense=1 and change=00 in the cycle after the Rs10 edge, then 0.
REQ-027 SHALL verify: Rs10, Rs10, none -> dispense=1 and change=01 one cycle after the second Rs10, and state IDLE.
REQ-028 SHALL verify: Rs10, then none for 5 cycles -> dispense stays 0 and credit is held; a following Rs5 -> dispense=1, change=00.
REQ-029 SHALL verify: Rs5, Rs5, Rs5 -> dispense only after the third coin, change=00.
REQ-030 SHALL verify: Rs10, then reset, then Rs5 -> no dispense; state CREDIT5 (prior credit lost).
REQ-031 SHALL verify: coin=11 interleaved as Rs5, 11, Rs10 -> same result as Rs5, Rs10 (dispense, change 00); back-to-back Rs5, Rs10, Rs10 -> vend then CREDIT10.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and encodings for the coin-operated vending machine.
// Credit is tracked in rupees in multiples of 5.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT5  = 2'd1,
    CREDIT10 = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_INV  = 2'b11;

  localparam logic [1:0] CHG_NONE  = 2'b00;
  localparam logic [1:0] CHG_5     = 2'b01;
  localparam logic [1:0] CHG_10    = 2'b10;

  localparam logic [4:0] VAL_0     = 5'd0;
  localparam logic [4:0] VAL_5     = 5'd5;
  localparam logic [4:0] VAL_10    = 5'd10;

  function automatic logic [4:0] credit_of(input state_t st);
    case (st)
      IDLE:     credit_of = VAL_0;
      CREDIT5:  credit_of = VAL_5;
      CREDIT10: credit_of = VAL_10;
      default:  credit_of = VAL_0;
    endcase
  endfunction

  // Only totals that remain below the price reach this mapping, so 0/5/10 suffice.
  function automatic state_t state_of(input logic [4:0] amount);
    case (amount)
      VAL_5:   state_of = CREDIT5;
      VAL_10:  state_of = CREDIT10;
      default: state_of = IDLE;
    endcase
  endfunction

  function automatic logic [1:0] change_of(input logic [4:0] amount);
    case (amount)
      VAL_5:   change_of = CHG_5;
      VAL_10:  change_of = CHG_10;
      default: change_of = CHG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/vending_coin_decode.sv
// Translates the 2-bit coin code into a rupee value and a legal-coin flag.
// The invalid code decodes to zero so it behaves like no coin at all.
module vending_coin_decode
  import vending_pkg::*;
(
  input  logic [1:0] code,
  output logic [4:0] value,
  output logic       valid
);

  // Code-to-value lookup.
  always_comb begin
    value = VAL_0;
    valid = 1'b0;
    case (code)
      COIN_5: begin
        value = VAL_5;
        valid = 1'b1;
      end
      COIN_10: begin
        value = VAL_10;
        valid = 1'b1;
      end
      COIN_NONE: begin
        value = VAL_0;
        valid = 1'b0;
      end
      default: begin
        value = VAL_0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vending_machine.sv
// Credit FSM for a single-product vending machine accepting Rs5 and Rs10 coins.
// dispense/change are registered and describe the coin sampled on the previous edge.
module vending_machine
  import vending_pkg::*;
#(
  parameter int PRICE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       dispense,
  output logic [1:0] change
);

  localparam logic [4:0] PRICE_V = 5'(PRICE);

  state_t     state_r;
  state_t     state_next_s;
  logic [4:0] coin_value_s;
  logic       coin_valid_s;
  logic [4:0] total_s;
  logic       vend_s;
  logic [1:0] change_next_s;

  vending_coin_decode u_coin_decode (
    .code  (coin),
    .value (coin_value_s),
    .valid (coin_valid_s)
  );

  // Next credit state and vend decision from current credit plus this coin.
  always_comb begin
    total_s       = credit_of(state_r) + coin_value_s;
    state_next_s  = state_r;
    vend_s        = 1'b0;
    change_next_s = CHG_NONE;
    if (!coin_valid_s) begin
      state_next_s = state_r;
    end else if (total_s >= PRICE_V) begin
      state_next_s  = IDLE;
      vend_s        = 1'b1;
      change_next_s = change_of(total_s - PRICE_V);
    end else begin
      state_next_s = state_of(total_s);
    end
  end

  // State and output registers; reset forfeits any credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      dispense <= 1'b0;
      change   <= CHG_NONE;
    end else begin
      state_r  <= state_next_s;
      dispense <= vend_s;
      change   <= change_next_s;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed and randomized checks of vending_machine (PRICE=15) against a
// rupee-arithmetic reference model.
module tb_vending_machine;
  import vending_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       dispense;
  logic [1:0] change;

  int total = 0;
  int bad = 0;

  int m_credit = 0;
  logic m_disp = 1'b0;
  logic [1:0] m_chg = 2'b00;

  vending_machine #(.PRICE(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .coin     (coin),
    .dispense (dispense),
    .change   (change)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic [1:0] c);
    int v;
    int t;
    if (r) begin
      m_credit = 0;
      m_disp   = 1'b0;
      m_chg    = 2'b00;
    end else begin
      v = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
      t = m_credit + v;
      if (v != 0 && t >= 15) begin
        m_credit = 0;
        m_disp   = 1'b1;
        m_chg    = 2'((t - 15) / 5);
      end else begin
        m_credit = t;
        m_disp   = 1'b0;
        m_chg    = 2'b00;
      end
    end
  endtask

  task automatic check(input string tag);
    state_t es;
    es = (m_credit == 0) ? IDLE : (m_credit == 5) ? CREDIT5 : CREDIT10;
    total++;
    assert (dispense === m_disp) else begin
      bad++;
      $error("FAIL %s dispense got=%0b exp=%0b", tag, dispense, m_disp);
    end
    total++;
    assert (change === m_chg) else begin
      bad++;
      $error("FAIL %s change got=%0b exp=%0b", tag, change, m_chg);
    end
    total++;
    assert (dut.state_r === es) else begin
      bad++;
      $error("FAIL %s state got=%0d exp=%0d", tag, dut.state_r, es);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] c, input string tag);
    reset = r;
    coin  = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    check(tag);
  endtask

  initial begin
    logic       rr;
    logic [1:0] cc;

    step(1'b1, 2'b00, "reset");

    step(1'b0, 2'b01, "r26_5");
    step(1'b0, 2'b10, "r26_10");
    step(1'b0, 2'b00, "r26_idle");

    step(1'b0, 2'b10, "r27_10a");
    step(1'b0, 2'b10, "r27_10b");
    step(1'b0, 2'b00, "r27_idle");

    step(1'b0, 2'b10, "r28_10");
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00, "r28_hold");
    step(1'b0, 2'b01, "r28_5");

    step(1'b0, 2'b01, "r29_5a");
    step(1'b0, 2'b01, "r29_5b");
    step(1'b0, 2'b01, "r29_5c");

    step(1'b0, 2'b10, "r30_10");
    step(1'b1, 2'b00, "r30_reset");
    step(1'b0, 2'b01, "r30_5");

    step(1'b1, 2'b10, "rst_prio");
    step(1'b0, 2'b01, "r31_5");
    step(1'b0, 2'b11, "r31_inv");
    step(1'b0, 2'b10, "r31_10");
    step(1'b0, 2'b01, "b2b_5");
    step(1'b0, 2'b10, "b2b_10a");
    step(1'b0, 2'b10, "b2b_10b");

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 31) == 0);
      cc = 2'($urandom_range(0, 3));
      step(rr, cc, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
